// File: rtl/acc_pkg.sv
// Shared constants and types for the accumulator-side blocks.
package acc_pkg;

  localparam int ACC_W     = 8;
  localparam int ACC_CNT_W = 16;

  localparam logic [7:0] ACC_MAX_STEP = 8'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } acc_state_e;

endpackage

// File: rtl/acc_diff_decoder_if.sv
// Sample-in / difference-out valid/ready bus of the difference decoder.
interface acc_diff_decoder_if #(
  parameter int W = 8
);

  logic [W-1:0] sum_in;
  logic         sum_valid;
  logic         sum_ready;
  logic [W-1:0] diff_out;
  logic         diff_valid;
  logic         diff_ready;

  modport master (
    output sum_in, sum_valid, diff_ready,
    input  sum_ready, diff_out, diff_valid
  );

  modport slave (
    input  sum_in, sum_valid, diff_ready,
    output sum_ready, diff_out, diff_valid
  );

endinterface

// File: rtl/acc_out_reg.sv
// Single-entry valid/ready output register; holds its entry while the consumer stalls.
module acc_out_reg
  import acc_pkg::*;
#(
  parameter int W = ACC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         free_o,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Free when empty or being drained this cycle, so a full-rate stream has no bubbles.
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/acc_diff_decoder.sv
// Reconstructs accumulator increments: diff = sum[n] - sum[n-1] mod 2^W.
// Optional sticky step-size checker enabled by ACC_DIFF_STEP_CHECK_EN.
module acc_diff_decoder
  import acc_pkg::*;
#(
  parameter int W     = ACC_W,
  parameter int CNT_W = ACC_CNT_W
`ifdef ACC_DIFF_STEP_CHECK_EN
  ,
  parameter int MAX_STEP = int'(ACC_MAX_STEP)
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  acc_diff_decoder_if.slave bus,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             busy
`ifdef ACC_DIFF_STEP_CHECK_EN
  ,
  output logic             step_err
`endif
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  acc_state_e       state_q, state_d;
  logic [W-1:0]     prev_q, prev_d;
  logic [W-1:0]     diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_free;
  logic             accept;

  // clear has priority over an incoming sample, so the sample is refused outright.
  assign bus.sum_ready = rst && !clear && out_free;
  assign accept        = bus.sum_valid && bus.sum_ready;
  assign diff_d        = bus.sum_in - prev_q;

  assign sample_cnt = cnt_q;
  assign busy       = (state_q != IDLE);

  acc_out_reg #(.W(W)) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .flush_i (clear),
    .load_i  (accept),
    .data_i  (diff_d),
    .ready_i (bus.diff_ready),
    .free_o  (out_free),
    .valid_o (bus.diff_valid),
    .data_o  (bus.diff_out)
  );

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (accept) state_d = RUN;
        RUN:     if (bus.diff_valid && !bus.diff_ready && bus.sum_valid) state_d = STALL;
        STALL:   if (bus.diff_ready) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    if (clear) begin
      prev_d = '0;
      cnt_d  = '0;
    end else if (accept) begin
      prev_d = bus.sum_in;
      cnt_d  = sat_inc(cnt_q);
    end
  end

  // Stage boundary: differencing state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      prev_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ACC_DIFF_STEP_CHECK_EN
  function automatic logic step_out_of_range(input logic signed [W-1:0] d);
    int dv;
    dv = int'(d);
    return (dv > MAX_STEP) || (dv < -MAX_STEP);
  endfunction

  logic step_err_q, step_err_d;

  always_comb begin
    step_err_d = step_err_q;
    if (clear) begin
      step_err_d = 1'b0;
    end else if (accept && step_out_of_range(diff_d)) begin
      step_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) step_err_q <= 1'b0;
    else      step_err_q <= step_err_d;
  end

  assign step_err = step_err_q;
`endif

endmodule

// File: doc/acc_diff_decoder.md
Name: acc_diff_decoder

Overview:
- Inverse of the accumulator. It takes a stream of running-sum samples and reconstructs the per-cycle increment that produced each one: diff = sum[n] - sum[n-1], computed modulo 2^W.
- Sits downstream of the accumulator output. It lets a consumer or checker recover the original accumulator input stream.
- Valid/ready on both sides, with a single-entry registered output stage.

Parameters:
- W, 8, data width of running sum and reconstructed difference
- CNT_W, 16, width of the sample counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- sum_in  in  W  running-sum sample from accumulator
- sum_valid  in  1  sum_in valid this cycle
- sum_ready  out  1  block accepts sum_in this cycle
- clear  in  1  synchronous restart: previous-sum reference back to 0, counter to 0
- diff_out  out  W  reconstructed increment
- diff_valid  out  1  diff_out holds an unconsumed result
- diff_ready  in  1  consumer accepts diff_out
- sample_cnt  out  CNT_W  number of differences produced since reset/clear, saturating
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, prev_sum=0, diff_out=0, diff_valid=0, sample_cnt=0, busy=0.
  - sum_ready is 0 while in reset.
- Handshake:
  - Accept occurs when sum_valid && sum_ready.
  - sum_ready = !diff_valid || diff_ready. The output register is free or being drained this cycle, so a full-rate stream passes with no bubbles.
  - Output transfer occurs when diff_valid && diff_ready.
  - diff_out and diff_valid stay stable while diff_valid=1 and diff_ready=0.
- Arithmetic:
  - On accept, diff_out <= sum_in - prev_sum, truncated to W bits (two's-complement wrap).
  - prev_sum <= sum_in.
  - Latency is 1 cycle from accept to diff_valid.
- Wrap-around: accumulator wrap is transparent. Example with W=8: prev=250, sum_in=4 gives diff=10.
- First sample after reset/clear: prev_sum=0, so diff = sum_in. This matches an accumulator that resets to 0.
- FSM:
  - IDLE: no sample since reset/clear. First accept goes to RUN.
  - RUN: diff_valid=1 and the consumer is ready or the output is empty. If diff_valid=1 and diff_ready=0 while sum_valid=1, go to STALL.
  - STALL: output held, sum_ready=0. On diff_ready=1, go to RUN. If that same cycle also accepts a new sample, stay in RUN with the new diff_out.
  - clear in any state goes to IDLE.
- sample_cnt:
  - Increments on each accept and saturates at 2^CNT_W-1.
  - clear and accept in the same cycle: clear wins. The sample is dropped, sum_ready is forced to 0 that cycle, and the count goes to 0.
- clear mid-operation:
  - diff_valid is forced to 0 next cycle; a pending unconsumed diff is discarded.
  - prev_sum=0 and sample_cnt=0.
- Simultaneous output transfer and accept: the new diff replaces the old in the same edge, with no gap.
- Reset mid-stream: everything returns to reset values immediately (asynchronous). Deassertion is synchronised by the surrounding reset tree; it is not handled here.

Optional Feature:
- Macro: ACC_DIFF_STEP_CHECK_EN.
- With the macro defined:
  - Adds parameter MAX_STEP (default 8'd15) and output step_err (1 bit, reset 0).
  - step_err is sticky. It sets when an accepted sample yields a signed diff outside [-MAX_STEP, MAX_STEP], and clears only on rst or clear.
- Without the macro: no step_err port and no comparison logic.

Decomposition:
- Package acc_pkg holds:
  - default width constants ACC_W=8 and ACC_CNT_W=16
  - the FSM state typedef {IDLE, RUN, STALL}
  - the MAX_STEP default
- One sub-module, acc_out_reg: the single-entry valid/ready output register with stall hold. It is reused by future accumulator-side blocks.
- The differencing datapath and counter stay in the top module.

Test Plan:
- Reset then stream sums 5,10,15,20 at full rate with diff_ready=1 -> diffs 5,5,5,5 one cycle after each accept; sample_cnt=4; no bubbles.
- Sums 250,4 (W=8) -> diffs 250, then 10 (wrap handled).
- Stream 5,10,15 with diff_ready=0 for 3 cycles after the first result -> diff_out holds 5; sum_ready=0; state=STALL. On release, diffs 5,5 follow in order with none lost.
- After sums 7,14, assert clear together with sum_valid (sum 21), then send sum 3 -> 21 dropped; sample_cnt=0; next diff=3.
- Drive rst low mid-stream with diff_valid=1 -> diff_valid=0, diff_out=0, sample_cnt=0 immediately, without waiting for a clock edge.
- With ACC_DIFF_STEP_CHECK_EN and MAX_STEP=15: sums 10,40 -> step_err=1 after the second accept and stays 1 through later good steps; clear -> step_err=0.
